// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU arbiter/sequencer.
// Flag vectors are packed {c_out, OVERFLOW, ZERO}, indexed by the FLAG_* constants.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int AOP_W   = 3;
    localparam int FLAGS_W = 3;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_COUT = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester favoured on a tie
// and is reloaded from ptr whenever update is pulsed.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       update,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (update) begin
            ptr_d = ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // A lone requester wins regardless of the pointer.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two clients: arbitrates, holds operands stable for the
// ALU latency, captures result and flags, and returns them to the issuing client.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int N       = 32,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [N-1:0]       req0_a,
    input  logic [N-1:0]       req0_b,
    input  logic               req0_cin,
    input  logic [AOP_W-1:0]   req0_op,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [N-1:0]       req1_a,
    input  logic [N-1:0]       req1_b,
    input  logic               req1_cin,
    input  logic [AOP_W-1:0]   req1_op,

    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [N-1:0]       rsp0_result,
    output logic [FLAGS_W-1:0] rsp0_flags,

    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [N-1:0]       rsp1_result,
    output logic [FLAGS_W-1:0] rsp1_flags,

    output logic [N-1:0]       alu_a,
    output logic [N-1:0]       alu_b,
    output logic               alu_cin,
    output logic [AOP_W-1:0]   alu_aop,
    input  logic [N-1:0]       alu_out,
    input  logic               alu_zero,
    input  logic               alu_overflow,
    input  logic               alu_cout,

    output logic               busy
);

    localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic               cin_q, cin_d;
    logic [AOP_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       result_q, result_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic               busy_q, busy_d;

    logic [1:0] grant;
    logic       rsp_hs;

    assign rsp_hs = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

    // After a response the non-owner gets priority on the next tie.
    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid}),
        .ptr    (~owner_q),
        .update (rsp_hs),
        .grant  (grant)
    );

    assign req0_ready = (state_q == IDLE) && grant[0];
    assign req1_ready = (state_q == IDLE) && grant[1];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        flags_d      = flags_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;

        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    owner_d = grant[1];
                    a_d     = grant[1] ? req1_a   : req0_a;
                    b_d     = grant[1] ? req1_b   : req0_b;
                    cin_d   = grant[1] ? req1_cin : req0_cin;
                    op_d    = grant[1] ? req1_op  : req0_op;
                    cnt_d   = CNT_W'(ALU_LAT);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    result_d            = alu_out;
                    flags_d[FLAG_ZERO]  = alu_zero;
                    flags_d[FLAG_OVF]   = alu_overflow;
                    flags_d[FLAG_COUT]  = alu_cout;
                    rsp0_valid_d        = ~owner_q;
                    rsp1_valid_d        = owner_q;
                    state_d             = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            op_q         <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_cin     = cin_q;
    assign alu_aop     = op_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_flags  = flags_q;
    assign rsp1_flags  = flags_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: main instance at ALU_LAT=1 checked through a response
// scoreboard, plus ALU_LAT=0 and ALU_LAT=3 instances for latency checks.
module tb_alu_arbiter;

    localparam int N = 32;

    typedef struct packed {
        logic [2:0]   flags;
        logic [N-1:0] result;
    } res_t;

    typedef struct packed {
        logic         owner;
        logic [2:0]   flags;
        logic [N-1:0] result;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         req0_valid, req0_ready, req0_cin;
    logic [N-1:0] req0_a, req0_b;
    logic [2:0]   req0_op;
    logic         req1_valid, req1_ready, req1_cin;
    logic [N-1:0] req1_a, req1_b;
    logic [2:0]   req1_op;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [N-1:0] rsp0_result, rsp1_result;
    logic [2:0]   rsp0_flags, rsp1_flags;
    logic [N-1:0] alu_a, alu_b, alu_out;
    logic         alu_cin, alu_zero, alu_overflow, alu_cout;
    logic [2:0]   alu_aop;
    logic         busy;

    // Reference adder used as the ALU stub: flags are {c_out, OVERFLOW, ZERO}.
    function automatic res_t alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic cin);
        logic [N:0] sum;
        res_t       r;
        sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        r.result   = sum[N-1:0];
        r.flags[2] = sum[N];
        r.flags[1] = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
        r.flags[0] = (sum[N-1:0] == '0);
        return r;
    endfunction

    res_t main_pipe;
    always @(posedge clk) main_pipe <= alu_model(alu_a, alu_b, alu_cin);
    assign alu_out      = main_pipe.result;
    assign alu_zero     = main_pipe.flags[0];
    assign alu_overflow = main_pipe.flags[1];
    assign alu_cout     = main_pipe.flags[2];

    alu_arbiter #(.N(N), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_aop(alu_aop),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_cout(alu_cout), .busy(busy)
    );

    // Side instances: index 0 is the combinational-ALU build, index 1 the 3-cycle build.
    logic         s_req0_valid [2], s_req0_ready [2], s_req0_cin [2];
    logic [N-1:0] s_req0_a [2], s_req0_b [2];
    logic [2:0]   s_req0_op [2];
    logic         s_req1_valid [2], s_req1_ready [2], s_req1_cin [2];
    logic [N-1:0] s_req1_a [2], s_req1_b [2];
    logic [2:0]   s_req1_op [2];
    logic         s_rsp0_valid [2], s_rsp0_ready [2], s_rsp1_valid [2], s_rsp1_ready [2];
    logic [N-1:0] s_rsp0_result [2], s_rsp1_result [2];
    logic [2:0]   s_rsp0_flags [2], s_rsp1_flags [2];
    logic [N-1:0] s_alu_a [2], s_alu_b [2], s_alu_out [2];
    logic         s_alu_cin [2], s_alu_zero [2], s_alu_ovf [2], s_alu_cout [2];
    logic [2:0]   s_alu_aop [2];
    logic         s_busy [2];

    res_t side_res [2];
    res_t p1, p2, p3;
    assign side_res[0] = alu_model(s_alu_a[0], s_alu_b[0], s_alu_cin[0]);
    always @(posedge clk) begin
        p1 <= alu_model(s_alu_a[1], s_alu_b[1], s_alu_cin[1]);
        p2 <= p1;
        p3 <= p2;
    end
    assign side_res[1] = p3;

    for (genvar g = 0; g < 2; g++) begin : g_side
        assign s_alu_out[g]  = side_res[g].result;
        assign s_alu_zero[g] = side_res[g].flags[0];
        assign s_alu_ovf[g]  = side_res[g].flags[1];
        assign s_alu_cout[g] = side_res[g].flags[2];

        alu_arbiter #(.N(N), .ALU_LAT((g == 0) ? 0 : 3)) u_side (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(s_req0_valid[g]), .req0_ready(s_req0_ready[g]),
            .req0_a(s_req0_a[g]), .req0_b(s_req0_b[g]),
            .req0_cin(s_req0_cin[g]), .req0_op(s_req0_op[g]),
            .req1_valid(s_req1_valid[g]), .req1_ready(s_req1_ready[g]),
            .req1_a(s_req1_a[g]), .req1_b(s_req1_b[g]),
            .req1_cin(s_req1_cin[g]), .req1_op(s_req1_op[g]),
            .rsp0_valid(s_rsp0_valid[g]), .rsp0_ready(s_rsp0_ready[g]),
            .rsp0_result(s_rsp0_result[g]), .rsp0_flags(s_rsp0_flags[g]),
            .rsp1_valid(s_rsp1_valid[g]), .rsp1_ready(s_rsp1_ready[g]),
            .rsp1_result(s_rsp1_result[g]), .rsp1_flags(s_rsp1_flags[g]),
            .alu_a(s_alu_a[g]), .alu_b(s_alu_b[g]), .alu_cin(s_alu_cin[g]),
            .alu_aop(s_alu_aop[g]), .alu_out(s_alu_out[g]), .alu_zero(s_alu_zero[g]),
            .alu_overflow(s_alu_ovf[g]), .alu_cout(s_alu_cout[g]), .busy(s_busy[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic applyStimulus(input logic client, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic [2:0] op, input bit push,
                                 input logic [N-1:0] exp_res, input logic [2:0] exp_flags);
        if (client == 1'b0) begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_op = op; req1_valid = 1'b1;
        end
        if (push) exp_q.push_back('{owner: client, flags: exp_flags, result: exp_res});
    endtask

    // Returns #1 after the accepting edge; the caller decides what to do with valid.
    task automatic waitAccept(input logic client, input string tag);
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if ((client == 1'b0) ? req0_ready : req1_ready) begin
                done = 1;
                checkOutput({tag, "_one_ready"}, {63'd0, req0_ready & req1_ready}, 64'd0);
            end
        end
        checkOutput({tag, "_accepted"}, {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic measureRsp(input logic client, output int lat);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            checkOutput("other_rsp_low", {63'd0, (client == 1'b0) ? rsp1_valid : rsp0_valid}, 64'd0);
            if ((client == 1'b0) ? rsp0_valid : rsp1_valid) lat = k + 1;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"},       {63'd0, busy},       64'd0);
        checkOutput({tag, "_req0_ready"}, {63'd0, req0_ready}, 64'd0);
        checkOutput({tag, "_req1_ready"}, {63'd0, req1_ready}, 64'd0);
        checkOutput({tag, "_rsp0_valid"}, {63'd0, rsp0_valid}, 64'd0);
        checkOutput({tag, "_rsp1_valid"}, {63'd0, rsp1_valid}, 64'd0);
        checkOutput({tag, "_alu_a"},      64'(alu_a),          64'd0);
        checkOutput({tag, "_alu_b"},      64'(alu_b),          64'd0);
        checkOutput({tag, "_alu_cin"},    {63'd0, alu_cin},    64'd0);
        checkOutput({tag, "_alu_aop"},    64'(alu_aop),        64'd0);
        checkOutput({tag, "_result"},     64'(rsp0_result),    64'd0);
        checkOutput({tag, "_flags"},      64'(rsp0_flags),     64'd0);
    endtask

    task automatic popCheck(input logic client);
        exp_t e;
        if (exp_q.size() == 0) begin
            checkOutput("sb_unexpected_rsp", 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            checkOutput("rsp_owner",  {63'd0, client}, {63'd0, e.owner});
            checkOutput("rsp_result", 64'((client == 1'b0) ? rsp0_result : rsp1_result), 64'(e.result));
            checkOutput("rsp_flags",  64'((client == 1'b0) ? rsp0_flags : rsp1_flags), 64'(e.flags));
        end
    endtask

    // Response monitor: every completed response handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid || rsp1_valid)
                checkOutput("rsp_exclusive", {63'd0, rsp0_valid & rsp1_valid}, 64'd0);
            if (rsp0_valid && rsp0_ready) popCheck(1'b0);
            if (rsp1_valid && rsp1_ready) popCheck(1'b1);
        end
    end

    task automatic sideTest(input int g, input int exp_lat, input string tag);
        bit done = 0;
        int lat = 0;
        s_req0_a[g] = 32'hABCDFFFF; s_req0_b[g] = 32'hFFFFFFFF;
        s_req0_cin[g] = 1'b1; s_req0_op[g] = 3'd2; s_req0_valid[g] = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (s_req0_ready[g]) done = 1;
        end
        checkOutput({tag, "_accepted"}, {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
        s_req0_valid[g] = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_rsp1_low"}, {63'd0, s_rsp1_valid[g]}, 64'd0);
            if (s_rsp0_valid[g]) lat = k + 1;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_result"}, 64'(s_rsp0_result[g]), 64'hABCDFFFF);
        checkOutput({tag, "_flags"}, 64'(s_rsp0_flags[g]), 64'd4);
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle_after"}, {63'd0, s_busy[g]}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] fa [6];
        logic [N-1:0] fb [6];
        logic         fc [6];
        res_t         r;
        int           lat, accepted, next0, next1;
        bit           found, who;

        rst_n = 1'b0;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0; req0_op = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0; req1_op = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int g = 0; g < 2; g++) begin
            s_req0_valid[g] = 0; s_req0_a[g] = '0; s_req0_b[g] = '0; s_req0_cin[g] = 0; s_req0_op[g] = '0;
            s_req1_valid[g] = 0; s_req1_a[g] = '0; s_req1_b[g] = '0; s_req1_cin[g] = 0; s_req1_op[g] = '0;
            s_rsp0_ready[g] = 1'b1; s_rsp1_ready[g] = 1'b1;
        end

        #12;
        checkIdle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] contention from idle");
        applyStimulus(1'b0, 32'h00000101, 32'h23213213, 1'b0, 3'd1, 1'b1, 32'h23213314, 3'b000);
        applyStimulus(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 3'd2, 1'b1, 32'h80000000, 3'b010);
        waitAccept(1'b0, "cont0");
        req0_valid = 1'b0;
        waitAccept(1'b1, "cont1");
        req1_valid = 1'b0;
        drain("cont");

        $display("[TB] fairness with both clients always valid");
        for (int i = 0; i < 6; i++) begin
            fa[i] = $urandom; fb[i] = $urandom; fc[i] = 1'($urandom_range(0, 1));
            r = alu_model(fa[i], fb[i], fc[i]);
            exp_q.push_back('{owner: 1'(i % 2), flags: r.flags, result: r.result});
        end
        applyStimulus(1'b0, fa[0], fb[0], fc[0], 3'd0, 1'b0, '0, '0);
        applyStimulus(1'b1, fa[1], fb[1], fc[1], 3'd1, 1'b0, '0, '0);
        next0 = 2; next1 = 3; accepted = 0;
        for (int n = 0; n < 6; n++) begin
            found = 0; who = 0;
            for (int i = 0; i < 50 && !found; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    found = 1;
                    who = req1_ready;
                end
            end
            checkOutput("fair_accept", {63'd0, found}, 64'd1);
            @(posedge clk);
            #1;
            if (found) accepted++;
            if (!who) begin
                if (next0 < 6) applyStimulus(1'b0, fa[next0], fb[next0], fc[next0], 3'(next0), 1'b0, '0, '0);
                else req0_valid = 1'b0;
                next0 += 2;
            end else begin
                if (next1 < 6) applyStimulus(1'b1, fa[next1], fb[next1], fc[next1], 3'(next1), 1'b0, '0, '0);
                else req1_valid = 1'b0;
                next1 += 2;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("fair_count", 64'(accepted), 64'd6);
        drain("fair");

        $display("[TB] single op on client 0");
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 3'd5, 1'b1, 32'h00000000, 3'b101);
        waitAccept(1'b0, "single");
        req0_valid = 1'b0;
        checkOutput("single_busy", {63'd0, busy}, 64'd1);
        checkOutput("single_alu_a", 64'(alu_a), 64'hFFFFFFFF);
        checkOutput("single_alu_aop", 64'(alu_aop), 64'd5);
        measureRsp(1'b0, lat);
        checkOutput("single_latency", 64'(lat), 64'd3);
        drain("single");

        $display("[TB] backpressure on client 0");
        rsp0_ready = 1'b0;
        applyStimulus(1'b0, 32'h12345678, 32'h11111111, 1'b1, 3'd3, 1'b1, 32'h2345678A, 3'b000);
        waitAccept(1'b0, "bp0");
        req0_valid = 1'b0;
        applyStimulus(1'b1, 32'h00000000, 32'h00000000, 1'b0, 3'd4, 1'b1, 32'h00000000, 3'b001);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (rsp0_valid) found = 1;
        end
        checkOutput("bp_rsp_seen", {63'd0, found}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
            checkOutput("bp_result", 64'(rsp0_result), 64'h2345678A);
            checkOutput("bp_flags", 64'(rsp0_flags), 64'd0);
            checkOutput("bp_req1_ready", {63'd0, req1_ready}, 64'd0);
            checkOutput("bp_alu_a", 64'(alu_a), 64'h12345678);
            checkOutput("bp_alu_b", 64'(alu_b), 64'h11111111);
            checkOutput("bp_alu_cin", {63'd0, alu_cin}, 64'd1);
            checkOutput("bp_alu_aop", 64'(alu_aop), 64'd3);
        end
        rsp0_ready = 1'b1;
        waitAccept(1'b1, "bp1");
        req1_valid = 1'b0;
        drain("bp");

        $display("[TB] reset during EXEC");
        applyStimulus(1'b0, 32'h00000005, 32'h00000006, 1'b0, 3'd7, 1'b0, '0, '0);
        waitAccept(1'b0, "rst");
        req0_valid = 1'b0;
        checkOutput("rst_busy_before", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checkOutput("postrst_rsp0", {63'd0, rsp0_valid}, 64'd0);
            checkOutput("postrst_rsp1", {63'd0, rsp1_valid}, 64'd0);
            checkOutput("postrst_busy", {63'd0, busy}, 64'd0);
        end

        $display("[TB] lone client 1 after reset");
        applyStimulus(1'b1, 32'h0000FFFF, 32'hFFFF0001, 1'b0, 3'd6, 1'b1, 32'h00000000, 3'b101);
        waitAccept(1'b1, "post");
        req1_valid = 1'b0;
        measureRsp(1'b1, lat);
        checkOutput("post_latency", 64'(lat), 64'd3);
        drain("post");

        $display("[TB] latency builds");
        sideTest(0, 2, "lat0");
        sideTest(1, 5, "lat3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
